// File: rtl/sweep_count_ctrl_if.sv
// Control, load-request and status signals of the sweep counter, grouped as one bundle.
interface sweep_count_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] lo_bound;
  logic [WIDTH-1:0] hi_bound;
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             busy;
  logic             wrap_pulse;
  logic             cfg_err;

  modport master (
    output start, stop, lo_bound, hi_bound, req0, req1, data0, data1,
    input  grant0, grant1, count, dir, busy, wrap_pulse, cfg_err
  );

  modport slave (
    input  start, stop, lo_bound, hi_bound, req0, req1, data0, data1,
    output grant0, grant1, count, dir, busy, wrap_pulse, cfg_err
  );
endinterface

// File: rtl/sweep_count_ctrl.sv
// Up/down sweep counter between programmable bounds with pause/resume and
// round-robin arbitrated count loads from two requesters.
module sweep_count_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LO_DEF = 10,
  parameter int unsigned HI_DEF = 98
) (
  input  logic                clk,
  input  logic                rst,
  sweep_count_ctrl_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic             dir_r;
  logic             resume_dir;
  logic             rr_ptr;
  logic             wrap_r;
  logic             cfg_r;

  logic             start_ok;
  logic             grant0;
  logic             grant1;
  logic             load;
  logic [WIDTH-1:0] load_raw;
  logic [WIDTH-1:0] load_val;

  // An accepted IDLE start owns the count register, so no grant that cycle.
  always_comb begin
    start_ok = (state == IDLE) && bus.start && (bus.lo_bound < bus.hi_bound);
    grant0   = !rst && !start_ok && bus.req0 && (!bus.req1 || !rr_ptr);
    grant1   = !rst && !start_ok && bus.req1 && (!bus.req0 || rr_ptr);
    load     = grant0 || grant1;
    load_raw = grant1 ? bus.data1 : bus.data0;
    if (load_raw < lo_r)
      load_val = lo_r;
    else if (load_raw > hi_r)
      load_val = hi_r;
    else
      load_val = load_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count_r    <= WIDTH'(LO_DEF);
      lo_r       <= WIDTH'(LO_DEF);
      hi_r       <= WIDTH'(HI_DEF);
      dir_r      <= 1'b1;
      resume_dir <= 1'b1;
      rr_ptr     <= 1'b0;
      wrap_r     <= 1'b0;
      cfg_r      <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      cfg_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (start_ok) begin
              lo_r    <= bus.lo_bound;
              hi_r    <= bus.hi_bound;
              count_r <= bus.lo_bound;
              dir_r   <= 1'b1;
              state   <= UP;
            end else begin
              cfg_r <= 1'b1;
            end
          end
        end
        UP: begin
          if (bus.stop) begin
            state      <= HOLD;
            resume_dir <= dir_r;
          end else if (!load) begin
            if (count_r == hi_r) begin
              count_r <= hi_r - WIDTH'(1);
              dir_r   <= 1'b0;
              state   <= DOWN;
              wrap_r  <= 1'b1;
            end else begin
              count_r <= count_r + WIDTH'(1);
            end
          end
        end
        DOWN: begin
          if (bus.stop) begin
            state      <= HOLD;
            resume_dir <= dir_r;
          end else if (!load) begin
            if (count_r == lo_r) begin
              count_r <= lo_r + WIDTH'(1);
              dir_r   <= 1'b1;
              state   <= UP;
              wrap_r  <= 1'b1;
            end else begin
              count_r <= count_r - WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (bus.stop)
            state <= IDLE;
          else if (bus.start)
            state <= resume_dir ? UP : DOWN;
        end
        default: state <= IDLE;
      endcase
      // A granted load overrides any step/reversal computed above.
      if (load) begin
        count_r <= load_val;
        rr_ptr  <= grant0;
      end
    end
  end

  assign bus.grant0     = grant0;
  assign bus.grant1     = grant1;
  assign bus.count      = count_r;
  assign bus.dir        = dir_r;
  assign bus.busy       = (state == UP) || (state == DOWN);
  assign bus.wrap_pulse = wrap_r;
  assign bus.cfg_err    = cfg_r;

endmodule

// File: doc/sweep_count_ctrl.md
SWEEP_COUNT_CTRL -- requirements
Module: sweep_count_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: counter and data width in bits, unsigned.
REQ-002 Parameter LO_DEF, default 10: lower bound loaded at reset.
REQ-003 Parameter HI_DEF, default 98: upper bound loaded at reset.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port start, input, 1: begin or resume a sweep.
REQ-007 Port stop, input, 1: pause a sweep, or abort it from HOLD.
REQ-008 Port lo_bound, input, WIDTH: requested lower bound, sampled only on an accepted start from IDLE.
REQ-009 Port hi_bound, input, WIDTH: requested upper bound, sampled only on an accepted start from IDLE.
REQ-010 Ports req0 and req1, input, 1 each: count-load requests from requesters 0 and 1.
REQ-011 Ports data0 and data1, input, WIDTH each: load values paired with req0 and req1.
REQ-012 Ports grant0 and grant1, output, 1 each: combinational grants; a grant is high in the cycle its load takes effect at the next edge.
REQ-013 Port count, output, WIDTH: registered counter value.
REQ-014 Port dir, output, 1: registered direction; 1 = up, 0 = down.
REQ-015 Port busy, output, 1: high in states UP and DOWN.
REQ-016 Port wrap_pulse, output, 1: registered; high for exactly one cycle after each direction reversal.
REQ-017 Port cfg_err, output, 1: registered; high for one cycle after a start rejected for invalid bounds.

Function
REQ-018 FSM states are IDLE, UP, DOWN and HOLD; internal registers are lo_r, hi_r, rr_ptr, state and resume_dir.
REQ-019 In IDLE, start with lo_bound < hi_bound captures the bounds into lo_r and hi_r, sets count to lo_bound and dir to 1, and enters UP.
REQ-020 In IDLE, start with lo_bound >= hi_bound is rejected: state, count and bounds are unchanged, and cfg_err pulses.
REQ-021 In UP, if count == hi_r, count becomes hi_r-1, dir becomes 0, state enters DOWN and wrap_pulse fires; otherwise count increments by 1.
REQ-022 In DOWN, if count == lo_r, count becomes lo_r+1, dir becomes 1, state enters UP and wrap_pulse fires; otherwise count decrements by 1.
REQ-023 The sweep period is therefore 2*(hi_r-lo_r) cycles, and each bound is held for exactly one cycle.
REQ-024 stop in UP or DOWN enters HOLD, freezes count, and records dir in resume_dir.
REQ-025 In HOLD, start returns to UP or DOWN according to resume_dir.
REQ-026 In HOLD, stop enters IDLE with count retained.
REQ-027 If start and stop are both high in HOLD, stop wins.
REQ-028 In UP or DOWN, start is ignored.
REQ-029 In IDLE, stop is ignored.
REQ-030 Loads are arbitrated in every state: a single requester is granted; if both req0 and req1 are high, the requester selected by rr_ptr is granted.
REQ-031 rr_ptr toggles to point at the other requester after each grant.
REQ-032 A granted load sets count to the granted data clamped to the range [lo_r, hi_r]; the load overrides that cycle's increment, decrement and reversal.
REQ-033 A granted load does not change state or dir.
REQ-034 A granted load that coincides with stop in UP or DOWN: both take effect, giving HOLD with the loaded count.
REQ-035 In the cycle an IDLE start is accepted, no grant is issued and requests are not consumed.
REQ-036 After a load to a bound value, the normal reversal rule applies on the next cycle.
REQ-037 All arithmetic is WIDTH-bit unsigned; count never leaves [lo_r, hi_r] after start, so no wrap-around occurs.
REQ-038 busy and wrap_pulse are decoded from registered state and flags only.

Reset
REQ-039 While rst is high at a clock edge: state = IDLE, count = LO_DEF, lo_r = LO_DEF, hi_r = HI_DEF, dir = 1, resume_dir = 1, rr_ptr = 0, and wrap_pulse = cfg_err = busy = 0.
REQ-040 While rst is high, grant0 and grant1 are forced to 0.
REQ-041 rst overrides start, stop and loads, including mid-sweep and from HOLD.

Verification
REQ-042 Bounds lo=10, hi=14 with start -> count sequence 10,11,12,13,14,13,12,11,10,11; wrap_pulse high after 14 and after 10; dir toggles at each reversal.
REQ-043 Bounds lo=20, hi=20 with start -> cfg_err pulses once; state stays IDLE; count stays 10.
REQ-044 Mid-sweep at count=12 going up, stop then start 3 cycles later -> count holds 12; busy=0 during HOLD; count resumes 13.
REQ-045 req0 and req1 held high for 4 cycles with data0=5, data1=200, and bounds 10/98 -> grants alternate 0,1,0,1; count takes 10,98,10,98.
REQ-046 rst asserted in DOWN at count=40 -> next edge count=10, dir=1, state IDLE, all grants 0.
